// File: rtl/frame_packer.sv
// Buffers up to two captured {f1, f2, count} frames and serialises each one as
// four 16-bit words (f1, f2, count, xor checksum) over a valid/ready stream.
module frame_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_stb,
    input  logic [15:0] count_in,
    input  logic [15:0] f1_in,
    input  logic [15:0] f2_in,
    input  logic        data_ready,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        data_last,
    output logic [7:0]  frame_cnt,
    output logic        overflow,
    output logic        busy
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned FILL_W = 2;
    localparam int unsigned DEPTH  = 2;

    typedef struct packed {
        logic [WORD_W-1:0] f1;
        logic [WORD_W-1:0] f2;
        logic [WORD_W-1:0] cnt;
    } frame_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        W_F1  = 3'd1,
        W_F2  = 3'd2,
        W_CNT = 3'd3,
        W_SUM = 3'd4
    } state_e;

    state_e             state_q, state_d;
    frame_t             mem_q [DEPTH];
    logic               wr_q;
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [WORD_W-1:0]  data_out_q, data_out_d;
    logic               data_valid_q, data_valid_d;
    logic               data_last_q, data_last_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;

    logic               capture, handshake, pop, push, drop;
    frame_t             src;

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign data_last  = data_last_q;
    assign frame_cnt  = frame_cnt_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;

    // FIFO bookkeeping: a full FIFO only takes a new frame when the head leaves this cycle
    always_comb begin
        capture     = wr_stb & ~wr_q;
        handshake   = data_valid_q & data_ready;
        pop         = handshake && (state_q == W_SUM);
        push        = capture && ((fill_q != FILL_W'(DEPTH)) || pop);
        drop        = capture && !push;
        rd_ptr_d    = rd_ptr_q ^ pop;
        wr_ptr_d    = wr_ptr_q ^ push;
        fill_d      = fill_q;
        unique case ({push, pop})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
        overflow_d  = overflow_q | drop;
        frame_cnt_d = frame_cnt_q + CNT_W'(pop);
    end

    // Next state plus registered word outputs; src is the frame the next state will present
    always_comb begin
        state_d      = state_q;
        data_out_d   = '0;
        data_valid_d = 1'b0;
        data_last_d  = 1'b0;
        unique case (state_q)
            IDLE:    if (fill_q != '0) state_d = W_F1;
            W_F1:    if (handshake) state_d = W_F2;
            W_F2:    if (handshake) state_d = W_CNT;
            W_CNT:   if (handshake) state_d = W_SUM;
            W_SUM:   if (handshake) state_d = (fill_q == FILL_W'(DEPTH)) ? W_F1 : IDLE;
            default: state_d = IDLE;
        endcase

        src = pop ? mem_q[~rd_ptr_q] : mem_q[rd_ptr_q];
        unique case (state_d)
            W_F1: begin
                data_out_d   = src.f1;
                data_valid_d = 1'b1;
            end
            W_F2: begin
                data_out_d   = src.f2;
                data_valid_d = 1'b1;
            end
            W_CNT: begin
                data_out_d   = src.cnt;
                data_valid_d = 1'b1;
            end
            W_SUM: begin
                data_out_d   = src.f1 ^ src.f2 ^ src.cnt;
                data_valid_d = 1'b1;
                data_last_d  = 1'b1;
            end
            default: ;
        endcase
        busy_d = (fill_d != '0) || (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wr_q         <= 1'b1;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            fill_q       <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            data_last_q  <= 1'b0;
            frame_cnt_q  <= '0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_stb;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            data_last_q  <= data_last_d;
            frame_cnt_q  <= frame_cnt_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
        end
    end

    // Frame storage needs no reset: fill_q alone decides which entries are live
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{f1: f1_in, f2: f2_in, cnt: count_in};
    end

endmodule

// File: tb/tb_frame_packer.sv
// Directed bench for frame_packer: inputs driven and outputs sampled on the
// falling clock edge, expected words computed by hand.
module tb_frame_packer;

    logic        clk;
    logic        reset_n;
    logic        wr_stb;
    logic [15:0] count_in;
    logic [15:0] f1_in;
    logic [15:0] f2_in;
    logic        data_ready;
    logic [15:0] data_out;
    logic        data_valid;
    logic        data_last;
    logic [7:0]  frame_cnt;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] got_data [$];
    logic        got_last [$];

    frame_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_stb     (wr_stb),
        .count_in   (count_in),
        .f1_in      (f1_in),
        .f2_in      (f2_in),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_last  (data_last),
        .frame_cnt  (frame_cnt),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset_n    = 1'b0;
        wr_stb     = 1'b0;
        data_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic capture(input logic [15:0] f1, input logic [15:0] f2, input logic [15:0] cnt);
        f1_in    = f1;
        f2_in    = f2;
        count_in = cnt;
        wr_stb   = 1'b1;
        @(negedge clk);
        wr_stb = 1'b0;
        @(negedge clk);
    endtask

    // Records words accepted by the downstream side; returns at the negedge of the last one
    task automatic collect(input int n, input int max_cyc, output bit timed_out);
        got_data.delete();
        got_last.delete();
        timed_out = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            if (data_valid === 1'b1 && data_ready === 1'b1) begin
                got_data.push_back(data_out);
                got_last.push_back(data_last);
                if (got_data.size() == n) begin
                    timed_out = 1'b0;
                    break;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        wr_stb     = 1'b1;
        data_ready = 1'b0;
        f1_in      = 16'hFE6B;
        f2_in      = 16'h2840;
        count_in   = 16'h0009;
        @(negedge clk);
        @(negedge clk);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", data_valid); end
        checks++; if (data_last !== 1'b0) begin errors++; $display("FAIL rst_last got %b want 0", data_last); end
        checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL rst_data got %h want 0000", data_out); end
        checks++; if (frame_cnt !== 8'h00) begin errors++; $display("FAIL rst_frame_cnt got %h want 00", frame_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        // Strobe already high when reset releases must not capture
        reset_n = 1'b1;
        begin
            int active = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (data_valid !== 1'b0 || busy !== 1'b0) active++;
            end
            checks++; if (active !== 0) begin errors++; $display("FAIL rst_release_capture got %0d active cycles want 0", active); end
        end
        wr_stb = 1'b0;
    endtask

    task automatic test_single_frame();
        bit to;
        logic [15:0] exp_w [4] = '{16'hFE6B, 16'h2840, 16'h0005, 16'hD62E};
        do_reset();
        data_ready = 1'b1;
        f1_in = 16'hFE6B; f2_in = 16'h2840; count_in = 16'h0005;
        wr_stb = 1'b1;
        @(negedge clk);
        wr_stb = 1'b0;
        checks++; if (data_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_pre valid/busy got %b/%b want 0/1", data_valid, busy); end
        @(negedge clk);
        checks++; if (data_valid !== 1'b1 || data_out !== 16'hFE6B) begin errors++; $display("FAIL single_latency valid/data got %b/%h want 1/FE6B", data_valid, data_out); end
        collect(4, 12, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL single_timeout got %0d words want 4", got_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (got_data[i] !== exp_w[i] || got_last[i] !== (i == 3)) begin
                    errors++; $display("FAIL single_word%0d got %h last %b want %h last %b", i, got_data[i], got_last[i], exp_w[i], (i == 3));
                    break;
                end
            end
        end
        @(negedge clk);
        checks++; if (data_valid !== 1'b0 || frame_cnt !== 8'h01 || busy !== 1'b0) begin errors++; $display("FAIL single_end valid/cnt/busy got %b/%h/%b want 0/01/0", data_valid, frame_cnt, busy); end
    endtask

    task automatic test_backpressure();
        bit to;
        int bad = 0;
        logic [15:0] exp_w [3] = '{16'h2840, 16'h1234, 16'hC41F};
        do_reset();
        capture(16'hFE6B, 16'h2840, 16'h1234);
        checks++; if (data_valid !== 1'b1 || data_out !== 16'hFE6B) begin errors++; $display("FAIL bp_f1 valid/data got %b/%h want 1/FE6B", data_valid, data_out); end
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (data_valid !== 1'b1 || data_out !== 16'h2840 || data_last !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0 (last data %h)", bad, data_out); end
        data_ready = 1'b1;
        collect(3, 10, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL bp_timeout got %0d words want 3", got_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (got_data[i] !== exp_w[i] || got_last[i] !== (i == 2)) begin
                    errors++; $display("FAIL bp_word%0d got %h last %b want %h", i, got_data[i], got_last[i], exp_w[i]);
                    break;
                end
            end
        end
        @(negedge clk);
        checks++; if (frame_cnt !== 8'h01) begin errors++; $display("FAIL bp_frame_cnt got %h want 01", frame_cnt); end
    endtask

    task automatic test_overflow();
        bit to;
        int extra = 0;
        logic [15:0] exp_w [8] = '{16'hFE6B, 16'h2840, 16'h0001, 16'hD62A,
                                   16'h0000, 16'h0000, 16'h0002, 16'h0002};
        do_reset();
        capture(16'hFE6B, 16'h2840, 16'h0001);
        capture(16'h0000, 16'h0000, 16'h0002);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
        capture(16'hFE6B, 16'h0000, 16'h0003);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
        data_ready = 1'b1;
        collect(8, 30, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL ovf_timeout got %0d words want 8", got_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (got_data[i] !== exp_w[i] || got_last[i] !== (i % 4 == 3)) begin
                    errors++; $display("FAIL ovf_word%0d got %h want %h", i, got_data[i], exp_w[i]);
                    break;
                end
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (data_valid !== 1'b0) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ovf_extra_words got %0d want 0", extra); end
        checks++; if (frame_cnt !== 8'h02 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_end cnt/ovf got %h/%b want 02/1", frame_cnt, overflow); end
    endtask

    task automatic test_back_to_back();
        int last_i = -1;
        logic [15:0] exp_w [12] = '{16'h1111, 16'h2222, 16'h0003, 16'h3330,
                                    16'h4444, 16'h5555, 16'h0006, 16'h1117,
                                    16'hFE6B, 16'h2840, 16'h0007, 16'hD62C};
        do_reset();
        capture(16'h1111, 16'h2222, 16'h0003);
        capture(16'h4444, 16'h5555, 16'h0006);
        got_data.delete();
        got_last.delete();
        data_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 3) begin
                checks++; if (data_last !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_sum_align last/busy got %b/%b want 1/1", data_last, busy); end
                f1_in = 16'hFE6B; f2_in = 16'h2840; count_in = 16'h0007;
                wr_stb = 1'b1;
            end else begin
                wr_stb = 1'b0;
            end
            if (data_valid === 1'b1) begin
                got_data.push_back(data_out);
                got_last.push_back(data_last);
                if (got_data.size() == 12) begin
                    last_i = i;
                    break;
                end
            end
            @(negedge clk);
        end
        wr_stb = 1'b0;
        checks++;
        if (last_i < 0) begin
            errors++; $display("FAIL b2b_timeout got %0d words want 12", got_data.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                if (got_data[i] !== exp_w[i] || got_last[i] !== (i % 4 == 3)) begin
                    errors++; $display("FAIL b2b_word%0d got %h want %h", i, got_data[i], exp_w[i]);
                    break;
                end
            end
        end
        checks++; if (last_i !== 11) begin errors++; $display("FAIL b2b_gapless got last word at cycle %0d want 11", last_i); end
        @(negedge clk);
        checks++; if (overflow !== 1'b0 || frame_cnt !== 8'h03) begin errors++; $display("FAIL b2b_end ovf/cnt got %b/%h want 0/03", overflow, frame_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        bit found = 1'b0;
        int residual = 0;
        do_reset();
        capture(16'hFE6B, 16'h2840, 16'h0777);
        capture(16'h0000, 16'h2840, 16'h0888);
        data_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (data_valid === 1'b1 && data_out === 16'h0777 && data_last === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL rmid_reach_cnt got data %h want 0777", data_out); end
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (data_valid !== 1'b0 || frame_cnt !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL rmid_reset valid/cnt/busy got %b/%h/%b want 0/00/0", data_valid, frame_cnt, busy); end
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (data_valid !== 1'b0 || data_out !== 16'h0000) residual++;
        end
        checks++; if (residual !== 0) begin errors++; $display("FAIL rmid_residual got %0d active cycles want 0", residual); end
    endtask

    task automatic test_hold_strobe();
        int hs = 0;
        do_reset();
        data_ready = 1'b1;
        f1_in = 16'hFE6B; f2_in = 16'h0000; count_in = 16'h00AA;
        wr_stb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (data_valid === 1'b1 && data_ready === 1'b1) hs++;
        end
        wr_stb = 1'b0;
        checks++; if (hs !== 4 || frame_cnt !== 8'h01) begin errors++; $display("FAIL hold_single_capture words/cnt got %0d/%h want 4/01", hs, frame_cnt); end
    endtask

    task automatic test_wrap();
        bit to;
        do_reset();
        data_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            capture(16'h0000, 16'h0000, 16'(i));
            collect(4, 10, to);
            checks++;
            if (to || got_data[0] !== 16'h0000 || got_data[1] !== 16'h0000 ||
                got_data[2] !== 16'(i) || got_data[3] !== 16'(i) || got_last[3] !== 1'b1) begin
                errors++; $display("FAIL wrap_frame%0d timeout %b got %0d words, sum %h want %h", i, to, got_data.size(),
                                   (got_data.size() == 4) ? got_data[3] : 16'hxxxx, 16'(i));
            end
            @(negedge clk);
            if (i == 254) begin
                checks++; if (frame_cnt !== 8'hFF) begin errors++; $display("FAIL wrap_cnt_ff got %h want FF", frame_cnt); end
            end
        end
        checks++; if (frame_cnt !== 8'h00 || overflow !== 1'b0) begin errors++; $display("FAIL wrap_cnt_00 cnt/ovf got %h/%b want 00/0", frame_cnt, overflow); end
    endtask

    initial begin
        reset_n    = 1'b0;
        wr_stb     = 1'b0;
        data_ready = 1'b0;
        f1_in      = '0;
        f2_in      = '0;
        count_in   = '0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        test_hold_strobe();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
